// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the multiply-controller family: controller state
// encoding, default array geometry and the lane-slice helper.
package tpu_ctrl_pkg;

  localparam int TPU_WIDTH_HEIGHT = 16;
  localparam int TPU_DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  // Low bit index of lane `lane` inside a packed lane vector.
  function automatic int lane_lo(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/input_skew_shift.sv
// Per-lane delay line for the west edge of the systolic array: lane k is
// delayed k cycles, with its valid bit travelling alongside the data.
module input_skew_shift
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = TPU_WIDTH_HEIGHT,
  parameter int DATA_W       = TPU_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [WIDTH_HEIGHT*DATA_W-1:0]   in_data,
  input  logic [WIDTH_HEIGHT-1:0]          in_vld,
  output logic [WIDTH_HEIGHT*DATA_W-1:0]   out_data,
  output logic [WIDTH_HEIGHT-1:0]          out_vld
);

  for (genvar k = 0; k < WIDTH_HEIGHT; k++) begin : g_lane
    if (k == 0) begin : g_pass
      assign out_data[DATA_W-1:0] = in_data[DATA_W-1:0];
      assign out_vld[0]           = in_vld[0];
    end else begin : g_dly
      logic [DATA_W-1:0] dat_p [k];
      logic              vld_p [k];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < k; s++) begin
            dat_p[s] <= '0;
            vld_p[s] <= 1'b0;
          end
        end else if (flush) begin
          for (int s = 0; s < k; s++) begin
            dat_p[s] <= '0;
            vld_p[s] <= 1'b0;
          end
        end else begin
          dat_p[0] <= in_data[lane_lo(k, DATA_W) +: DATA_W];
          vld_p[0] <= in_vld[k];
          for (int s = 1; s < k; s++) begin
            dat_p[s] <= dat_p[s-1];
            vld_p[s] <= vld_p[s-1];
          end
        end
      end

      assign out_data[lane_lo(k, DATA_W) +: DATA_W] = dat_p[k-1];
      assign out_vld[k]                             = vld_p[k-1];
    end
  end

endmodule

// File: rtl/input_mem_stream_ctrl.sv
// Responder for the input-memory handshake: reads N rows starting at base_addr
// and feeds them, diagonally skewed and lane-masked, into the array's west edge.
module input_mem_stream_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = TPU_WIDTH_HEIGHT,
  parameter int DATA_W       = TPU_DATA_WIDTH,
  parameter int ADDR_WIDTH   = WIDTH_HEIGHT * 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               input_mem_enable,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [$clog2(WIDTH_HEIGHT)-1:0]    input_matrix_col_num,
  input  logic [$clog2(WIDTH_HEIGHT)-1:0]    intermed_dim,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [WIDTH_HEIGHT*DATA_W-1:0]     mem_rd_data,
  output logic [WIDTH_HEIGHT*DATA_W-1:0]     array_data,
  output logic [WIDTH_HEIGHT-1:0]            array_lane_valid,
  output logic                               input_mem_done
);

  localparam int            CW        = $clog2(WIDTH_HEIGHT);
  localparam logic [CW-1:0] LAST_LANE = CW'(WIDTH_HEIGHT - 1);

  ctrl_state_e              state_q, state_d;
  logic                     armed_q, armed_d;
  logic [CW-1:0]            n_m1_q, n_m1_d;
  logic [CW-1:0]            dim_q, dim_d;
  logic [CW-1:0]            row_q, row_d;
  logic [CW-1:0]            drain_q, drain_d;
  logic                     rd_en_d;
  logic [ADDR_WIDTH-1:0]    addr_d;
  logic                     done_d;
  logic                     flush;
  logic                     vld_p0;
  logic [WIDTH_HEIGHT-1:0]  lane_mask;
  logic [WIDTH_HEIGHT-1:0]  lane_vld_in;
  logic [WIDTH_HEIGHT*DATA_W-1:0] lane_data_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      armed_q        <= 1'b1;
      n_m1_q         <= '0;
      dim_q          <= '0;
      row_q          <= '0;
      drain_q        <= '0;
      mem_rd_en      <= 1'b0;
      mem_addr       <= '0;
      input_mem_done <= 1'b0;
      vld_p0         <= 1'b0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      n_m1_q         <= n_m1_d;
      dim_q          <= dim_d;
      row_q          <= row_d;
      drain_q        <= drain_d;
      mem_rd_en      <= rd_en_d;
      mem_addr       <= addr_d;
      input_mem_done <= done_d;
      vld_p0         <= flush ? 1'b0 : mem_rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    n_m1_d  = n_m1_q;
    dim_d   = dim_q;
    row_d   = row_q;
    drain_d = drain_q;
    rd_en_d = mem_rd_en;
    addr_d  = mem_addr;
    done_d  = 1'b0;
    flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (input_mem_enable && armed_q) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
          addr_d  = base_addr;
          n_m1_d  = input_matrix_col_num;
          dim_d   = intermed_dim;
          row_d   = '0;
        end
      end
      ST_READ: begin
        if (!input_mem_enable) begin
          state_d = ST_IDLE;
          rd_en_d = 1'b0;
          flush   = 1'b1;
        end else if (row_q == n_m1_q) begin
          state_d = ST_DRAIN;
          rd_en_d = 1'b0;
          drain_d = '0;
        end else begin
          row_d  = row_q + CW'(1);
          addr_d = mem_addr + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // Leaves once the highest lane has shown its last word.
        if (!input_mem_enable) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (drain_q == LAST_LANE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          armed_d = 1'b0;
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!input_mem_enable) armed_d = 1'b1;
  end

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < WIDTH_HEIGHT; k++) lane_mask[k] = (k <= int'(dim_q));
  end

  assign lane_vld_in = lane_mask & {WIDTH_HEIGHT{vld_p0}};

  // Stage p0: memory return, masked per lane before entering the skew line.
  always_comb begin
    lane_data_in = '0;
    for (int k = 0; k < WIDTH_HEIGHT; k++) begin
      if (lane_vld_in[k])
        lane_data_in[lane_lo(k, DATA_W) +: DATA_W] = mem_rd_data[lane_lo(k, DATA_W) +: DATA_W];
    end
  end

  input_skew_shift #(
    .WIDTH_HEIGHT (WIDTH_HEIGHT),
    .DATA_W       (DATA_W)
  ) u_skew (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (lane_data_in),
    .in_vld   (lane_vld_in),
    .out_data (array_data),
    .out_vld  (array_lane_valid)
  );

endmodule

// File: tb/tb_input_mem_stream_ctrl.sv
// Directed + randomized bench for input_mem_stream_ctrl with a cycle-indexed
// reference model of the read/skew/done timeline.
module tb_input_mem_stream_ctrl;

  localparam int W  = 16;
  localparam int DW = 8;
  localparam int AW = W * 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            input_mem_enable;
  logic [AW-1:0]   base_addr;
  logic [3:0]      input_matrix_col_num;
  logic [3:0]      intermed_dim;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [W*DW-1:0] mem_rd_data;
  logic [W*DW-1:0] array_data;
  logic [W-1:0]    array_lane_valid;
  logic            input_mem_done;

  logic [W*DW-1:0] mem_img [16];
  logic [AW-1:0]   cur_base;
  wire  [AW-1:0]   mem_off = mem_addr - cur_base;

  int n_assert = 0;
  int n_fail   = 0;

  input_mem_stream_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .input_mem_enable     (input_mem_enable),
    .base_addr            (base_addr),
    .input_matrix_col_num (input_matrix_col_num),
    .intermed_dim         (intermed_dim),
    .mem_rd_en            (mem_rd_en),
    .mem_addr             (mem_addr),
    .mem_rd_data          (mem_rd_data),
    .array_data           (array_data),
    .array_lane_valid     (array_lane_valid),
    .input_mem_done       (input_mem_done)
  );

  always #5 clk = ~clk;

  // Input memory: one-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_img[mem_off[3:0]];
    else           mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  function automatic logic [AW-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input bit counting);
    for (int i = 0; i < 16; i++) begin
      if (counting) mem_img[i] = {W{8'(i + 1)}};
      else          mem_img[i] = rand_wide();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_en"}, 128'(mem_rd_en), 128'd0);
    chk({tag, " addr"},  128'(mem_addr), 128'd0);
    chk({tag, " valid"}, 128'(array_lane_valid), 128'd0);
    chk({tag, " data"},  array_data, 128'd0);
    chk({tag, " done"},  128'(input_mem_done), 128'd0);
  endtask

  // Expected outputs in cycle t of a transfer of n rows, lanes 0..dm active,
  // aborted by enable=0 sampled at the edge ending cycle ab (0 = no abort).
  task automatic check_cycle(input int t, input int n, input int dm, input int ab);
    bit              live;
    bit              exp_rd;
    bit              exp_done;
    logic [W-1:0]    exp_vld;
    logic [W*DW-1:0] exp_dat;
    live     = (ab == 0) || (t <= ab);
    exp_rd   = live && (t >= 1) && (t <= n);
    exp_done = (ab == 0) && (t == n + W + 1);
    exp_vld  = '0;
    exp_dat  = '0;
    for (int k = 0; k < W; k++) begin
      if (live && k <= dm && t >= 2 + k && t <= n + 1 + k) begin
        exp_vld[k]          = 1'b1;
        exp_dat[k*DW +: DW] = mem_img[t-2-k][k*DW +: DW];
      end
    end
    chk($sformatf("rd_en t=%0d", t), 128'(mem_rd_en), 128'(exp_rd));
    if (exp_rd) chk($sformatf("addr t=%0d", t), mem_addr, cur_base + AW'(t - 1));
    chk($sformatf("lane_valid t=%0d", t), 128'(array_lane_valid), 128'(exp_vld));
    chk($sformatf("array_data t=%0d", t), array_data, exp_dat);
    chk($sformatf("done t=%0d", t), 128'(input_mem_done), 128'(exp_done));
  endtask

  // Called at a negedge with the DUT idle and armed; the next posedge is E0.
  task automatic run_xfer(input logic [AW-1:0] b, input int n, input int dm,
                          input int ab, input int ncyc);
    cur_base             = b;
    base_addr            = b;
    input_matrix_col_num = 4'(n - 1);
    intermed_dim         = 4'(dm);
    input_mem_enable     = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      check_cycle(t, n, dm, ab);
      if (t == 1) begin
        base_addr            = rand_wide();
        input_matrix_col_num = 4'($urandom);
        intermed_dim         = 4'($urandom);
      end
      if (t == ab) input_mem_enable = 1'b0;
    end
  endtask

  task automatic idle_gap();
    input_mem_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset                = 1'b0;
    input_mem_enable     = 1'b0;
    base_addr            = '0;
    input_matrix_col_num = '0;
    intermed_dim         = '0;
    cur_base             = '0;
    fill_mem(1'b1);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic transfer; enable held three cycles past done must not restart.
    run_xfer(AW'(16'h0010), 4, 15, 0, 24);
    // One low cycle re-arms; the next raise starts at the following edge.
    idle_gap();
    fill_mem(1'b0);
    run_xfer(rand_wide(), 3, 15, 0, 3 + W + 2);
    idle_gap();

    // Lane mask: only lanes 0..2 carry data.
    fill_mem(1'b0);
    run_xfer(rand_wide(), 1, 2, 0, 19);
    idle_gap();

    // Address wrap from all-ones.
    run_xfer({AW{1'b1}}, 2, 15, 0, 20);
    idle_gap();

    // Abort during READ, then a clean transfer.
    fill_mem(1'b0);
    run_xfer(rand_wide(), 8, 15, 3, 6);
    @(negedge clk);
    run_xfer(rand_wide(), 5, $urandom_range(0, 15), 0, 5 + W + 2);
    idle_gap();

    // Asynchronous reset in DRAIN, then an N=1 transfer.
    run_xfer(rand_wide(), 4, 15, 0, 8);
    #1 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    chk_all_zero("in_reset");
    input_mem_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_xfer(rand_wide(), 1, 15, 0, 19);
    idle_gap();

    // Randomized transfers.
    for (int r = 0; r < 4; r++) begin
      int n;
      int dm;
      n  = $urandom_range(1, 16);
      dm = $urandom_range(0, 15);
      fill_mem(1'b0);
      run_xfer(rand_wide(), n, dm, 0, n + W + 2);
      idle_gap();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
